control_fsm: RTL

Multicycle control unit for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states. Per state it drives the datapath mux selects, write enables and the 4-bit ALU operation code. It sits directly upstream of the ALU: it generates ALUControl, and it consumes Zero/Negative/Carry/Overflow to resolve branches.

---
 rtl/riscv_pkg.sv | 72 +++++++
 rtl/alu_decoder.sv | 26 ++
 rtl/control_fsm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I multicycle control unit: FSM states, ALU codes,
// opcodes and datapath mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_UPPER    = 4'd12
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format implied by the opcode; formats without an immediate read as I.
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7b5 of R-type and OP-IMM instructions onto the ALU operation code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_control_o
);

  // SUB only exists for R-type; bit 30 of an addi is immediate data.
  always_comb begin
    alu_control_o = ALU_ADD;
    case (funct3_i)
      3'b000:  alu_control_o = (op_i == OP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control_o = ALU_SLL;
      3'b010:  alu_control_o = ALU_SLT;
      3'b011:  alu_control_o = ALU_SLTU;
      3'b100:  alu_control_o = ALU_XOR;
      3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control_o = ALU_OR;
      default: alu_control_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, write enables and ALU operation.
module control_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       Carry,
  input  logic       Overflow,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       IllegalInstr
);

  state_e     state_q, state_d;
  logic [3:0] dec_alu_op;
  logic       branch_taken;

  alu_decoder u_alu_decoder (
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Branch condition from the flags of rs1 - rs2 computed this cycle.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      3'b100:  branch_taken = Negative ^ Overflow;
      3'b101:  branch_taken = ~(Negative ^ Overflow);
      3'b110:  branch_taken = ~Carry;
      3'b111:  branch_taken = Carry;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_REGB;
    ALUControl   = ALU_ADD;
    ImmSrc       = imm_src_of(op);
    IllegalInstr = 1'b0;

    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
            IllegalInstr = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_REGA;
        ALUControl = dec_alu_op;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_REGA;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu_op;
        state_d    = S_ALUWB;
      end
      S_UPPER: begin
        ALUSrcA = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JALRADR: begin
        ALUSrcA = SRCA_REGA;
        ALUSrcB = SRCB_IMM;
        state_d = S_JAL;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_REGA;
        ALUControl = ALU_SUB;
        PCWrite    = branch_taken;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // No architectural side effect may happen while reset is held.
    if (reset) begin
      PCWrite      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

endmodule
